// File: rtl/mem_pkg.sv
// mem_pkg: funct3 encodings and access helpers shared by the data memory blocks
package mem_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  typedef struct packed {
    logic       v;
    logic       we;
    logic [1:0] lane;
    logic [2:0] f3;
    logic       ill;
    logic       mis;
  } meta_t;
  function automatic logic legal_funct3(input logic [2:0] f3, input logic we);
    return (f3 inside {F3_B, F3_H, F3_W}) || (!we && (f3 inside {F3_BU, F3_HU}));
  endfunction
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
    return (f3[1:0] == 2'b01 && a[0]) || (f3 == F3_W && a != 2'b00);
  endfunction
  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] lane,
                                              input logic [2:0] f3);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lane, 3'b000} +: 8];
    h = word[{lane[1], 4'b0000} +: 16];
    return f3 == F3_B  ? {{24{b[7]}}, b} :
           f3 == F3_BU ? {24'b0, b} :
           f3 == F3_H  ? {{16{h[15]}}, h} :
           f3 == F3_HU ? {16'b0, h} : word;
  endfunction
endpackage

// File: rtl/byte_ram.sv
// byte_ram: 2^SIZE x 32-bit array with per-byte write enables and registered read
module byte_ram #(
  parameter int SIZE = 14
) (
  input  logic            CLK,
  input  logic [3:0]      BE,
  input  logic [SIZE-1:0] IDX,
  input  logic [31:0]     WDATA,
  output logic [31:0]     RDATA
);
  logic [31:0] mem [2**SIZE];
  always_ff @(posedge CLK) begin
    for (int b = 0; b < 4; b++)
      if (BE[b]) mem[IDX][b*8 +: 8] <= WDATA[b*8 +: 8];
    RDATA <= mem[IDX];
  end
endmodule

// File: rtl/data_ram.sv
// data_ram: pipelined byte/half/word data memory with fault flags and RD_LAT-cycle responses
module data_ram import mem_pkg::*; #(
  parameter int SIZE   = 14,
  parameter int WORD   = 32,
  parameter int RD_LAT = 1
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            REQ,
  input  logic            WE,
  input  logic [WORD-1:0] A,
  input  logic [WORD-1:0] WD,
  input  logic [2:0]      FUNCT3,
  output logic [WORD-1:0] RD,
  output logic            VALID,
  output logic            MISALIGN,
  output logic            ILLEGAL
);
  if (WORD != 32) begin : g_bad_word
    $error("data_ram: WORD must be 32");
  end
  if (RD_LAT < 1 || RD_LAT > 3) begin : g_bad_lat
    $error("data_ram: RD_LAT must be 1..3");
  end
  logic            ill, mis, wr;
  logic [3:0]      be;
  logic [WORD-1:0] wdata, rdata, raw;
  meta_t           meta [RD_LAT];
  meta_t           last;
  logic            unused_hi;
  assign unused_hi = ^A[WORD-1:SIZE+2];
  always_comb begin
    ill   = !legal_funct3(FUNCT3, WE);
    mis   = !ill && misaligned(FUNCT3, A[1:0]);
    wr    = REQ && WE && !RST && !ill && !mis;
    be    = !wr ? 4'b0000 :
            FUNCT3[1:0] == 2'b00 ? 4'b0001 << A[1:0] :
            FUNCT3[1:0] == 2'b01 ? (A[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wdata = FUNCT3[1:0] == 2'b00 ? {4{WD[7:0]}} :
            FUNCT3[1:0] == 2'b01 ? {2{WD[15:0]}} : WD;
  end
  byte_ram #(.SIZE(SIZE)) u_ram (
    .CLK(CLK), .BE(be), .IDX(A[SIZE+1:2]), .WDATA(wdata), .RDATA(rdata)
  );
  // stage 0 is captured alongside the synchronous array read, so it lines up with rdata
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < RD_LAT; i++) meta[i] <= '0;
    end else begin
      meta[0] <= {REQ, WE, A[1:0], FUNCT3, ill, mis};
      for (int i = 1; i < RD_LAT; i++) meta[i] <= meta[i-1];
    end
  end
  if (RD_LAT > 1) begin : g_pipe
    logic [WORD-1:0] wq [RD_LAT-1];
    always_ff @(posedge CLK) begin
      wq[0] <= rdata;
      for (int i = 1; i < RD_LAT - 1; i++) wq[i] <= wq[i-1];
    end
    assign raw = wq[RD_LAT-2];
  end else begin : g_direct
    assign raw = rdata;
  end
  assign last     = meta[RD_LAT-1];
  assign VALID    = last.v;
  assign ILLEGAL  = last.v && last.ill;
  assign MISALIGN = last.v && last.mis;
  assign RD       = (last.v && !last.we && !last.ill && !last.mis) ?
                    load_extend(raw, last.lane, last.f3) : '0;
endmodule

// File: tb/tb_data_ram.sv
// tb_data_ram: three latencies of data_ram driven in lockstep against a word-array reference model
module tb_data_ram;
  localparam int SIZE = 4;
  localparam int N    = 1 << SIZE;
  localparam int MAXC = 3000;
  logic        CLK = 0, RST = 1, REQ = 0, WE = 0;
  logic [31:0] A = 0, WD = 0;
  logic [2:0]  FUNCT3 = 0;
  logic [31:0] rd    [1:3];
  logic        valid [1:3];
  logic        mis   [1:3];
  logic        ill   [1:3];
  data_ram #(.SIZE(SIZE), .RD_LAT(1)) u1 (.CLK(CLK), .RST(RST), .REQ(REQ), .WE(WE), .A(A), .WD(WD),
    .FUNCT3(FUNCT3), .RD(rd[1]), .VALID(valid[1]), .MISALIGN(mis[1]), .ILLEGAL(ill[1]));
  data_ram #(.SIZE(SIZE), .RD_LAT(2)) u2 (.CLK(CLK), .RST(RST), .REQ(REQ), .WE(WE), .A(A), .WD(WD),
    .FUNCT3(FUNCT3), .RD(rd[2]), .VALID(valid[2]), .MISALIGN(mis[2]), .ILLEGAL(ill[2]));
  data_ram #(.SIZE(SIZE), .RD_LAT(3)) u3 (.CLK(CLK), .RST(RST), .REQ(REQ), .WE(WE), .A(A), .WD(WD),
    .FUNCT3(FUNCT3), .RD(rd[3]), .VALID(valid[3]), .MISALIGN(mis[3]), .ILLEGAL(ill[3]));
  always #5 CLK = ~CLK;
  typedef struct {
    bit        rst;
    bit        v;
    bit [31:0] rd;
    bit        mis;
    bit        ill;
  } resp_t;
  resp_t     hist [MAXC];
  bit [31:0] mem  [N];
  int        t = 0, checks = 0, errors = 0;
  // response owed in cycle t by a DUT of latency lat, unless a reset fell in between
  function automatic resp_t expect_at(int lat);
    resp_t r = '{default: 0};
    int    c = t - lat;
    if (c < 0 || !hist[c].v) return r;
    for (int k = c + 1; k < t; k++) if (hist[k].rst) return r;
    r = hist[c];
    r.rst = 0;
    return r;
  endfunction
  task automatic model(input bit we, input bit [31:0] a, input bit [31:0] wd, input bit [2:0] f3,
                       output resp_t r);
    int        lane = int'(a[1:0]);
    int        idx  = int'((a >> 2) % N);
    int        nb   = 1 << f3[1:0];
    bit [31:0] mask, val;
    r = '{default: 0};
    r.v   = 1;
    r.ill = (f3 == 3'b011) || (f3 >= 3'b110) || (we && f3 >= 3'b100);
    r.mis = !r.ill && (lane % nb != 0);
    mask  = 32'((64'd1 << (8 * nb)) - 1);
    if (!r.ill && !r.mis) begin
      if (we) begin
        mem[idx] = (mem[idx] & ~(mask << (8 * lane))) | ((wd & mask) << (8 * lane));
      end else begin
        val = (mem[idx] >> (8 * lane)) & mask;
        if (!f3[2] && nb < 4 && val[8*nb-1]) val = val | ~mask;
        r.rd = val;
      end
    end
  endtask
  task automatic cmp(input string name, input logic [34:0] got, input logic [34:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got v=%0b mis=%0b ill=%0b rd=%08h expected v=%0b mis=%0b ill=%0b rd=%08h",
               name, got[34], got[33], got[32], got[31:0], exp[34], exp[33], exp[32], exp[31:0]);
    end
  endtask
  task automatic step(input bit rst, input bit req, input bit we, input bit [31:0] a,
                      input bit [31:0] wd, input bit [2:0] f3);
    resp_t r = '{default: 0};
    @(negedge CLK);
    if (t >= MAXC) begin
      $display("FAIL cycle_budget got %0d cycles expected below %0d", t, MAXC);
      $fatal(1);
    end
    if (t >= 1)
      for (int l = 1; l <= 3; l++) begin
        resp_t e = expect_at(l);
        cmp($sformatf("lat%0d_cyc%0d", l, t), {valid[l], mis[l], ill[l], rd[l]},
            {e.v, e.mis, e.ill, e.rd});
      end
    RST = rst; REQ = req; WE = we; A = a; WD = wd; FUNCT3 = f3;
    if (rst) r.rst = 1;
    else if (req) model(we, a, wd, f3, r);
    hist[t] = r;
    t++;
  endtask
  task automatic idle();
    step(0, 0, 0, 0, 0, 0);
  endtask
  task automatic lit(input int l, input string name, input bit v, input bit m, input bit i,
                     input bit [31:0] x);
    cmp(name, {valid[l], mis[l], ill[l], rd[l]}, {v, m, i, x});
  endtask
  task automatic ld1(input bit we, input bit [31:0] a, input bit [31:0] wd, input bit [2:0] f3,
                     input string name, input bit [31:0] x, input bit m, input bit i);
    step(0, 1, we, a, wd, f3);
    idle();
    lit(1, name, 1, m, i, x);
  endtask
  initial begin
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    idle();
    lit(1, "reset_l1", 0, 0, 0, 0);
    lit(3, "reset_l3", 0, 0, 0, 0);
    for (int i = 0; i < N; i++) step(0, 1, 1, 32'(4 * i), 32'(i + 1), 3'b010);
    step(0, 1, 1, 32'h10, 32'hDEADBEEF, 3'b010);
    ld1(0, 32'h10, 0, 3'b010, "lw_after_sw", 32'hDEADBEEF, 0, 0);
    step(0, 1, 1, 32'h13, 32'h80, 3'b000);
    ld1(0, 32'h13, 0, 3'b000, "lb_sign", 32'hFFFFFF80, 0, 0);
    ld1(0, 32'h13, 0, 3'b100, "lbu_zero", 32'h00000080, 0, 0);
    ld1(0, 32'h10, 0, 3'b010, "lw_after_sb", 32'h80ADBEEF, 0, 0);
    step(0, 1, 1, 32'h12, 32'h1234, 3'b001);
    ld1(0, 32'h12, 0, 3'b101, "lhu", 32'h00001234, 0, 0);
    ld1(0, 32'h11, 0, 3'b001, "lh_misalign", 0, 1, 0);
    ld1(1, 32'h12, 0, 3'b010, "sw_misalign", 0, 1, 0);
    ld1(0, 32'h10, 0, 3'b010, "lw_after_bad_sw", 32'h1234BEEF, 0, 0);
    ld1(1, 32'h10, 32'hFFFFFFFF, 3'b100, "sbu_illegal", 0, 0, 1);
    ld1(0, 32'h10, 0, 3'b011, "ld011_illegal", 0, 0, 1);
    ld1(1, 32'h11, 32'hFFFF, 3'b101, "shu_ill_wins", 0, 0, 1);
    ld1(0, 32'h10, 0, 3'b010, "lw_after_illegal", 32'h1234BEEF, 0, 0);
    ld1(0, 32'h40, 0, 3'b010, "wrap_word0", 32'd1, 0, 0);
    ld1(0, 32'hFFFFFFC4, 0, 3'b010, "wrap_high_bits", 32'd2, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 32'(4 * i), 0, 3'b010);
    lit(3, "lat3_r1", 1, 0, 0, 32'd1);
    idle();
    lit(3, "lat3_r2", 1, 0, 0, 32'd2);
    idle();
    lit(3, "lat3_r3", 1, 0, 0, 32'd3);
    idle();
    lit(3, "lat3_r4", 1, 0, 0, 32'd4);
    idle();
    lit(3, "lat3_end", 0, 0, 0, 0);
    step(0, 1, 0, 32'h18, 0, 3'b010);
    step(1, 0, 0, 0, 0, 0);
    idle();
    lit(2, "lat2_rst_drop", 0, 0, 0, 0);
    idle();
    lit(2, "lat2_rst_drop_late", 0, 0, 0, 0);
    step(1, 1, 1, 32'h14, 32'hCAFEF00D, 3'b010);
    ld1(0, 32'h14, 0, 3'b010, "sw_under_rst", 32'd6, 0, 0);
    for (int i = 0; i < 2000; i++)
      step($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
           $urandom, $urandom, 3'($urandom_range(0, 7)));
    for (int i = 0; i < 4; i++) idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
